// File: rtl/bin2bcd_display_feeder.sv
// Bus-slave binary->BCD converter (serial double-dabble) feeding a hex-display register; BCD_SATURATE_EN clamps overflow to 999999.
// Latency: display write pulses 20 edges after the accepting write; writes while busy are dropped and flagged in sticky drop.
module bin2bcd_display_feeder #(
  parameter int BIN_W = 20
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        chipSelect,
  input  logic        write,
  input  logic        read,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        dispChipSelect,
  output logic        dispWrite,
  output logic [31:0] dispWriteData,
  output logic        busy
);

  localparam int ACC_W = 28;

  typedef enum logic [1:0] {IDLE, SHIFT, PUSH} state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   operand;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W-1:0]   acc_adj;
  logic [ACC_W-1:0]   acc_sh;
  logic [4:0]         step;
  logic [23:0]        result;
  logic [23:0]        res_nxt;
  logic               ovf, ovf_nxt, drop;
  logic               wr_req, rd_req, last_step;
  logic               unused_bits;

  assign wr_req      = chipSelect && write;
  assign rd_req      = chipSelect && read && !write;
  assign last_step   = (state == SHIFT) && (step == 5'(BIN_W - 1));
  assign busy        = (state != IDLE);
  assign unused_bits = ^{writeData[31:BIN_W], acc_adj[ACC_W-1]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_req) state_nxt = SHIFT;
      SHIFT:   if (last_step) state_nxt = PUSH;
      PUSH:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // One double-dabble step: correct digits >= 5, then shift the next operand bit in.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < ACC_W / 4; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    acc_sh  = {acc_adj[ACC_W-2:0], operand[BIN_W-1]};
    ovf_nxt = (acc_sh[27:24] != 4'd0);
`ifdef BCD_SATURATE_EN
    res_nxt = ovf_nxt ? 24'h999999 : acc_sh[23:0];
`else
    res_nxt = acc_sh[23:0];
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      operand        <= '0;
      acc            <= '0;
      step           <= '0;
      result         <= '0;
      ovf            <= 1'b0;
      drop           <= 1'b0;
      readData       <= '0;
      dispChipSelect <= 1'b0;
      dispWrite      <= 1'b0;
      dispWriteData  <= '0;
    end else begin
      dispChipSelect <= 1'b0;
      dispWrite      <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_req) begin
            operand <= writeData[BIN_W-1:0];
            acc     <= '0;
            step    <= '0;
            ovf     <= 1'b0;
            drop    <= 1'b0;
          end
        end
        SHIFT: begin
          acc     <= acc_sh;
          operand <= operand << 1;
          step    <= step + 5'd1;
          // Final step: the pulse is registered so it occupies exactly the PUSH cycle.
          if (last_step) begin
            result         <= res_nxt;
            ovf            <= ovf_nxt;
            dispWriteData  <= {8'h00, res_nxt};
            dispChipSelect <= 1'b1;
            dispWrite      <= 1'b1;
          end
        end
        default: ;
      endcase
      if (wr_req && state != IDLE) drop <= 1'b1;
      if (rd_req) readData <= {busy, ovf, drop, 5'b0, result};
    end
  end

endmodule

// File: tb/tb_bin2bcd_display_feeder.sv
// Scoreboarded bench: driver predicts pushes/readback from an arithmetic model; a monitor checks every display write and hold.
module tb_bin2bcd_display_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        chipSelect = 1'b0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] writeData = '0;
  logic [31:0] readData;
  logic        dispChipSelect;
  logic        dispWrite;
  logic [31:0] dispWriteData;
  logic        busy;

  bin2bcd_display_feeder #(.BIN_W(20)) dut (
    .clk(clk), .rst(rst), .chipSelect(chipSelect), .write(write), .read(read),
    .writeData(writeData), .readData(readData), .dispChipSelect(dispChipSelect),
    .dispWrite(dispWrite), .dispWriteData(dispWriteData), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    int          at;
  } push_t;

  push_t       sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_pushed = '0;
  int          last_a = -100;
  logic        drop_m = 1'b0;
  logic [23:0] res_prev = '0;
  logic [23:0] res_new = '0;
  logic        ovf_new = 1'b0;
  logic [31:0] rd_m = '0;

  function automatic logic [23:0] ref_bcd(input int unsigned v);
    int unsigned x;
    logic [23:0] r;
    x = v % 1000000;
`ifdef BCD_SATURATE_EN
    if (v > 999999) x = 999999;
`endif
    r = '0;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (rst) begin
      chk("busy", 32'(busy), 32'((cyc >= last_a) && (cyc <= last_a + 20)));
      if (dispWrite) begin
        chk("disp_cs_push", 32'(dispChipSelect), 32'd1);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_push: dispWriteData %h at cycle %0d, none expected", dispWriteData, cyc);
        end else begin
          push_t p;
          p = sb.pop_front();
          chk("push_data", dispWriteData, p.dat);
          chk("push_cycle", 32'(cyc), 32'(p.at));
          last_pushed = p.dat;
        end
      end else begin
        chk("disp_cs_idle", 32'(dispChipSelect), 32'd0);
        chk("disp_hold", dispWriteData, last_pushed);
      end
    end
  end

  // Called at a falling edge; the request is sampled at the next rising edge.
  task automatic issue_write(input logic [31:0] d, input bit with_read);
    int e;
    int unsigned v;
    chipSelect = 1'b1;
    write      = 1'b1;
    read       = with_read;
    writeData  = d;
    e = cyc + 1;
    if (e >= last_a + 22) begin
      v        = int'(d[19:0]);
      res_prev = res_new;
      res_new  = ref_bcd(v);
      ovf_new  = (v > 999999);
      last_a   = e;
      drop_m   = 1'b0;
      sb.push_back('{dat: {8'h00, res_new}, at: e + 20});
    end else begin
      drop_m = 1'b1;
    end
    @(negedge clk);
    chipSelect = 1'b0;
    write      = 1'b0;
    read       = 1'b0;
    if (with_read) chk("rd_hold_on_write", readData, rd_m);
  endtask

  task automatic bus_write(input logic [31:0] d, input bit with_read);
    @(negedge clk);
    issue_write(d, with_read);
  endtask

  task automatic bus_read();
    int e;
    logic b, o;
    logic [23:0] r;
    @(negedge clk);
    chipSelect = 1'b1;
    read       = 1'b1;
    e = cyc + 1;
    b = (e - 1 >= last_a) && (e - 1 <= last_a + 20);
    if (e >= last_a + 21) begin
      r = res_new;
      o = ovf_new;
    end else begin
      r = res_prev;
      o = 1'b0;
    end
    rd_m = {b, o, drop_m, 5'b0, r};
    @(negedge clk);
    chipSelect = 1'b0;
    read       = 1'b0;
    chk("read", readData, rd_m);
  endtask

  task automatic wait_idle();
    while (cyc + 1 < last_a + 22) @(negedge clk);
  endtask

  task automatic do_reset(input int hold, input bit wr_after, input logic [31:0] d);
    @(negedge clk);
    rst = 1'b0;
    sb.delete();
    last_pushed = '0;
    last_a      = -100;
    drop_m      = 1'b0;
    res_prev    = '0;
    res_new     = '0;
    ovf_new     = 1'b0;
    rd_m        = '0;
    #1;
    chk("rst_readData", readData, 32'h0);
    chk("rst_dispCS", 32'(dispChipSelect), 32'h0);
    chk("rst_dispWrite", 32'(dispWrite), 32'h0);
    chk("rst_dispData", dispWriteData, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    repeat (hold) @(negedge clk);
    rst = 1'b1;
    if (wr_after) issue_write(d, 1'b0);
  endtask

  initial begin
    logic [31:0] v;
    // Reset state, then a write on the very first edge out of reset
    do_reset(3, 1'b1, 32'd123456);
    wait_idle();
    bus_read();
    chk("req030_read", readData, 32'h00123456);

    bus_write(32'd0, 1'b0);
    wait_idle();
    bus_write(32'd999999, 1'b0);
    wait_idle();
    bus_read();

    bus_write(32'h000FFFFF, 1'b0);
    wait_idle();
    bus_read();
    chk("ovf_bit", 32'(readData[30]), 32'd1);

    // Second write mid-conversion is dropped
    bus_write(32'd111, 1'b0);
    repeat (4) @(negedge clk);
    bus_write(32'd222, 1'b0);
    wait_idle();
    bus_read();
    chk("req033_read", readData, 32'h20000111);

    // Write and read together: write wins, readData holds
    bus_write(32'hABC01234, 1'b1);
    wait_idle();

    // Deselected strobes are ignored
    @(negedge clk);
    write = 1'b1; read = 1'b1; writeData = 32'd5;
    @(negedge clk);
    write = 1'b0; read = 1'b0;
    chk("cs0_rd_hold", readData, rd_m);
    chk("cs0_busy", 32'(busy), 32'd0);

    // Reset mid-conversion: no push may follow
    bus_write(32'd555555, 1'b0);
    repeat (9) @(negedge clk);
    do_reset(2, 1'b0, 32'd0);
    repeat (30) @(negedge clk);
    bus_read();
    do_reset(1, 1'b1, 32'd777);
    wait_idle();
    bus_read();

    for (int i = 0; i < 60; i++) begin
      repeat ($urandom_range(0, 25)) @(negedge clk);
      if ($urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 2))
          0:       v = 32'($urandom_range(0, 999999));
          1:       v = {12'h000, 20'($urandom)};
          default: v = $urandom;
        endcase
        bus_write(v, 1'b0);
      end else begin
        bus_read();
      end
    end

    wait_idle();
    repeat (5) @(negedge clk);
    bus_read();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
